// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared mode encodings, fixed TMDS code words and TERC4 table
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'b00,
        MODE_VIDEO  = 2'b01,
        MODE_ISLAND = 2'b10,
        MODE_GUARD  = 2'b11
    } tmds_mode_e;

    localparam int DEFAULT_CNT_W = 5;

    // Indexed by the two control bits {c1,c0}
    localparam logic [3:0][9:0] CTRL_CODE = {
        10'b1010101011,
        10'b0101010100,
        10'b0010101011,
        10'b1101010100
    };

    // Already bit-reversed so that bit 0 is the first bit on the wire
    localparam logic [15:0][9:0] TERC4_TABLE = {
        10'b1100001101, 10'b1100011010, 10'b1000111001, 10'b0111000101,
        10'b0110001101, 10'b0011100110, 10'b1001110010, 10'b0011001101,
        10'b0011110010, 10'b0111000110, 10'b0111100010, 10'b1000111010,
        10'b0100011101, 10'b0010011101, 10'b1100011001, 10'b0011100101
    };

    localparam logic [9:0] GUARD_VID_EVEN = 10'b0011001101;
    localparam logic [9:0] GUARD_VID_ODD  = 10'b1100110010;
    localparam logic [9:0] GUARD_ISL      = 10'b1100110010;

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        return TERC4_TABLE[nib];
    endfunction

endpackage

// File: rtl/tmds_encoder_mc_if.sv
// rtl/tmds_encoder_mc_if.sv - pixel-side bus between scheduler and multi-lane TMDS encoder
interface tmds_encoder_mc_if #(
    parameter int NUM_CH = 3
);
    logic [1:0]             i_mode;
    logic                   i_guard_sel;
    logic [NUM_CH*8-1:0]    i_data;
    logic [NUM_CH*2-1:0]    i_ctrl;
    logic [NUM_CH*4-1:0]    i_terc4;
    logic [NUM_CH*10-1:0]   o_tmds;

    modport master (
        output i_mode, i_guard_sel, i_data, i_ctrl, i_terc4,
        input  o_tmds
    );

    modport slave (
        input  i_mode, i_guard_sel, i_data, i_ctrl, i_terc4,
        output o_tmds
    );
endinterface

// File: rtl/tmds_lane_enc.sv
// rtl/tmds_lane_enc.sv - one TMDS lane: 2-stage encoder with private running disparity (TMDS_DISP_MON_EN adds range flag)
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter bit ODD_LANE = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  tmds_mode_e  mode_i,
    input  logic        guard_sel_i,
    input  logic [7:0]  data_i,
    input  logic [1:0]  ctrl_i,
    input  logic [3:0]  terc4_i,
    output logic [9:0]  tmds_o
`ifdef TMDS_DISP_MON_EN
    ,
    output logic        cnt_oor_o
`endif
);

    localparam logic signed [CNT_W-1:0] ZERO  = '0;
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    logic [3:0] ones_s1;
    logic       use_xnor;
    logic [8:0] qm_d;

    tmds_mode_e mode_q;
    logic       gsel_q;
    logic [8:0] qm_q;
    logic [1:0] ctrl_q;
    logic [3:0] terc4_q;

    logic [3:0]              n1;
    logic                    q8;
    logic signed [CNT_W-1:0] diff;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]              tmds_q, tmds_d;

    // Transition-minimising stage
    always_comb begin
        ones_s1 = '0;
        for (int i = 0; i < 8; i++) ones_s1 = ones_s1 + 4'(data_i[i]);
        use_xnor = (ones_s1 > 4'd4) || (ones_s1 == 4'd4 && !data_i[0]);
        qm_d[0]  = data_i[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_CTRL;
            gsel_q  <= 1'b0;
            qm_q    <= '0;
            ctrl_q  <= '0;
            terc4_q <= '0;
        end else begin
            mode_q  <= mode_i;
            gsel_q  <= guard_sel_i;
            qm_q    <= qm_d;
            ctrl_q  <= ctrl_i;
            terc4_q <= terc4_i;
        end
    end

    // DC-balancing stage; every non-video symbol restarts disparity at zero
    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + 4'(qm_q[i]);
        q8     = qm_q[8];
        diff   = $signed(CNT_W'({n1, 1'b0})) - EIGHT;
        tmds_d = CTRL_CODE[ctrl_q];
        cnt_d  = ZERO;
        case (mode_q)
            MODE_VIDEO: begin
                if (cnt_q == ZERO || n1 == 4'd4) begin
                    tmds_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = q8 ? cnt_q + diff : cnt_q - diff;
                end else if ((cnt_q > ZERO && n1 > 4'd4) || (cnt_q < ZERO && n1 < 4'd4)) begin
                    tmds_d = {1'b1, q8, ~qm_q[7:0]};
                    cnt_d  = cnt_q + (q8 ? TWO : ZERO) - diff;
                end else begin
                    tmds_d = {1'b0, q8, qm_q[7:0]};
                    cnt_d  = cnt_q + diff - (q8 ? ZERO : TWO);
                end
            end
            MODE_ISLAND: tmds_d = terc4_code(terc4_q);
            MODE_GUARD:  tmds_d = gsel_q ? GUARD_ISL : (ODD_LANE ? GUARD_VID_ODD : GUARD_VID_EVEN);
            MODE_CTRL:   tmds_d = CTRL_CODE[ctrl_q];
            default:     tmds_d = CTRL_CODE[ctrl_q];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmds_q <= CTRL_CODE[0];
            cnt_q  <= ZERO;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_o = tmds_q;

`ifdef TMDS_DISP_MON_EN
    localparam logic signed [CNT_W-1:0] TEN = CNT_W'(10);
    assign cnt_oor_o = (cnt_d > TEN) || (cnt_d < -TEN);
`endif

endmodule

// File: rtl/tmds_encoder_mc.sv
// rtl/tmds_encoder_mc.sv - NUM_CH-lane TMDS/TERC4/guard encoder top; TMDS_DISP_MON_EN adds sticky o_disp_err
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tmds_encoder_mc_if.slave   bus
`ifdef TMDS_DISP_MON_EN
    ,
    output logic               o_disp_err
`endif
);

    tmds_mode_e        mode;
    logic [NUM_CH-1:0] oor;

    assign mode = tmds_mode_e'(bus.i_mode);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        tmds_mode_e lane_mode;

        // Lane 0 carries the TERC4 header during the island guard band
        if (n == 0) begin : g_hdr
            assign lane_mode = (mode == MODE_GUARD && bus.i_guard_sel) ? MODE_ISLAND : mode;
        end else begin : g_plain
            assign lane_mode = mode;
        end

        tmds_lane_enc #(
            .CNT_W    (CNT_W),
            .ODD_LANE (1'(n % 2))
        ) u_lane (
            .clk_i       (i_clk),
            .rst_i       (i_rst),
            .mode_i      (lane_mode),
            .guard_sel_i (bus.i_guard_sel),
            .data_i      (bus.i_data[8*n +: 8]),
            .ctrl_i      (bus.i_ctrl[2*n +: 2]),
            .terc4_i     (bus.i_terc4[4*n +: 4]),
            .tmds_o      (bus.o_tmds[10*n +: 10])
`ifdef TMDS_DISP_MON_EN
            ,
            .cnt_oor_o   (oor[n])
`endif
        );

`ifndef TMDS_DISP_MON_EN
        assign oor[n] = 1'b0;
`endif
    end

`ifdef TMDS_DISP_MON_EN
    logic err_q, err_d;

    always_comb err_d = err_q | (|oor);

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_disp_err = err_q;
`else
    logic unused_oor;
    assign unused_oor = ^oor;
`endif

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// tb/tb_tmds_encoder_mc.sv - randomized and directed bench for tmds_encoder_mc against a behavioural model
module tb_tmds_encoder_mc;

    localparam int NUM_CH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_encoder_mc_if #(.NUM_CH(NUM_CH)) bus();

`ifdef TMDS_DISP_MON_EN
    logic disp_err;
`endif

    tmds_encoder_mc #(.NUM_CH(NUM_CH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus)
`ifdef TMDS_DISP_MON_EN
        ,
        .o_disp_err (disp_err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b @%0t", tag, got[9:0], exp[9:0], $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]          mode;
        logic                gsel;
        logic [NUM_CH*8-1:0] data;
        logic [NUM_CH*2-1:0] ctrl;
        logic [NUM_CH*4-1:0] terc4;
    } item_t;

    // HDMI TERC4 table as printed, leftmost char = q_out[0]
    logic [9:0] terc4_tx [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    item_t      pend, src;
    logic       src_vid;
    int         cnt [NUM_CH];
    logic [9:0] exp_sym [NUM_CH];

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] d, b;
        d = s[9] ? ~s[7:0] : s[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++) b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return b;
    endfunction

    function automatic logic [9:0] ref_enc(input int n, input item_t it);
        logic [7:0] d, qm;
        logic [3:0] nib;
        logic       xn, q8;
        int         ones, n1, diff;
        nib = it.terc4[4*n +: 4];
        case (it.mode)
            2'b01: begin
                d    = it.data[8*n +: 8];
                ones = $countones(d);
                xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                q8   = !xn;
                n1   = $countones(qm);
                diff = 2 * n1 - 8;
                if (cnt[n] == 0 || n1 == 4) begin
                    cnt[n] += q8 ? diff : -diff;
                    return {~q8, q8, q8 ? qm : ~qm};
                end else if ((cnt[n] > 0 && n1 > 4) || (cnt[n] < 0 && n1 < 4)) begin
                    cnt[n] += 2 * int'(q8) - diff;
                    return {1'b1, q8, ~qm};
                end else begin
                    cnt[n] += diff - 2 * int'(!q8);
                    return {1'b0, q8, qm};
                end
            end
            2'b10: begin
                cnt[n] = 0;
                return rev10(terc4_tx[nib]);
            end
            2'b11: begin
                cnt[n] = 0;
                if (it.gsel) return (n == 0) ? rev10(terc4_tx[nib]) : 10'b1100110010;
                return (n % 2 == 0) ? 10'b0011001101 : 10'b1100110010;
            end
            default: begin
                cnt[n] = 0;
                case (it.ctrl[2*n +: 2])
                    2'b00:   return 10'b1101010100;
                    2'b01:   return 10'b0010101011;
                    2'b10:   return 10'b0101010100;
                    default: return 10'b1010101011;
                endcase
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                exp_sym[n] = 10'b1101010100;
                cnt[n]     = 0;
            end
            pend    = '0;
            src_vid = 1'b0;
        end else begin
            src     = pend;
            src_vid = (pend.mode == 2'b01);
            for (int n = 0; n < NUM_CH; n++) exp_sym[n] = ref_enc(n, pend);
            pend = '{mode: bus.i_mode, gsel: bus.i_guard_sel, data: bus.i_data,
                     ctrl: bus.i_ctrl, terc4: bus.i_terc4};
        end
        #1;
        for (int n = 0; n < NUM_CH; n++) begin
            chk($sformatf("sym_l%0d", n), 32'(bus.o_tmds[10*n +: 10]), 32'(exp_sym[n]));
            if (src_vid)
                chk($sformatf("decode_l%0d", n), 32'(dec(bus.o_tmds[10*n +: 10])), 32'(src.data[8*n +: 8]));
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic gsel,
                         input logic [NUM_CH*8-1:0] data, input logic [NUM_CH*2-1:0] ctrl,
                         input logic [NUM_CH*4-1:0] terc4);
        bus.i_mode      = mode;
        bus.i_guard_sel = gsel;
        bus.i_data      = data;
        bus.i_ctrl      = ctrl;
        bus.i_terc4     = terc4;
    endtask

    task automatic drive_rand(input logic [1:0] mode);
        logic [31:0] r0, r1, r2;
        r0 = $urandom;
        r1 = $urandom;
        r2 = $urandom;
        drive(mode, r2[31], r0[NUM_CH*8-1:0], r1[NUM_CH*2-1:0], r2[NUM_CH*4-1:0]);
    endtask

    initial begin
        drive(2'b00, 1'b0, '0, '0, '0);
        rst = 1'b1;
        step();
        step();
        for (int n = 0; n < NUM_CH; n++)
            chk($sformatf("reset_l%0d", n), 32'(bus.o_tmds[10*n +: 10]), 32'(10'b1101010100));

        rst = 1'b0;
        drive(2'b00, 1'b0, '0, {NUM_CH{2'b01}}, '0);
        step();
        chk("ctrl_latency", 32'(bus.o_tmds[9:0]), 32'(10'b1101010100));
        step();
        for (int n = 0; n < NUM_CH; n++)
            chk($sformatf("ctrl01_l%0d", n), 32'(bus.o_tmds[10*n +: 10]), 32'(10'b0010101011));

        drive(2'b01, 1'b0, '0, '0, '0);
        step();
        step();
        chk("vid00_a", 32'(bus.o_tmds[9:0]), 32'(10'b0100000000));
        step();
        chk("vid00_b", 32'(bus.o_tmds[9:0]), 32'(10'b1111111111));
        drive(2'b00, 1'b0, '0, '0, '0);
        step();
        chk("vid00_c", 32'(bus.o_tmds[9:0]), 32'(10'b0100000000));

        drive(2'b10, 1'b0, '0, '0, '0);
        step();
        drive(2'b11, 1'b0, '0, '0, '0);
        step();
        chk("island_l0", 32'(bus.o_tmds[9:0]), 32'(10'b0011100101));
        drive(2'b00, 1'b0, '0, '0, '0);
        step();
        chk("vguard_l0", 32'(bus.o_tmds[9:0]), 32'(10'b0011001101));
        chk("vguard_l1", 32'(bus.o_tmds[19:10]), 32'(10'b1100110010));

        drive(2'b11, 1'b1, '0, '0, {{(NUM_CH-1){4'h3}}, 4'b1010});
        step();
        drive(2'b00, 1'b0, '0, '0, '0);
        step();
        chk("iguard_l0", 32'(bus.o_tmds[9:0]), 32'(10'b0011100110));
        chk("iguard_l1", 32'(bus.o_tmds[19:10]), 32'(10'b1100110010));

        drive(2'b01, 1'b0, {NUM_CH{8'hFF}}, '0, '0);
        repeat (4) step();
        drive(2'b00, 1'b0, {NUM_CH{8'hFF}}, '0, '0);
        step();
        drive(2'b01, 1'b0, {NUM_CH{8'hFF}}, '0, '0);
        step();
        step();
        chk("ff_after_ctrl", 32'(bus.o_tmds[9:0]), 32'(10'b1000000000));
        step();

        for (int i = 0; i < 5; i++) begin
            drive_rand(2'b01);
            step();
        end
        rst = 1'b1;
        step();
        chk("rst_mid_a", 32'(bus.o_tmds[9:0]), 32'(10'b1101010100));
        rst = 1'b0;
        drive_rand(2'b01);
        step();
        chk("rst_mid_b", 32'(bus.o_tmds[9:0]), 32'(10'b1101010100));
        drive_rand(2'b01);
        step();
        chk("no_x", 32'($isunknown(bus.o_tmds)), 32'(0));

        for (int i = 0; i < 10000; i++) begin
            drive_rand(2'b01);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            rst = (r[7:0] < 8'd5);
            drive_rand((r[15:8] < 8'd160) ? 2'b01 : r[17:16]);
            step();
        end
        rst = 1'b0;
        chk("no_x_end", 32'($isunknown(bus.o_tmds)), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
